// File: rtl/fetch_queue.sv
// Instruction fetcher: owns the PC, issues single-outstanding reads to the
// I-side memory and buffers {pc, instruction} pairs in a circular FIFO for decode.
//
// state | meaning
// IDLE  | no read outstanding; issue when a FIFO slot is (or is becoming) free
// REQ   | read outstanding at mem_address; responses are pushed
// DROP  | read outstanding but squashed by a flush; response is discarded
module fetch_queue #(
  parameter int               width    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [width-1:0] RESET_PC = 32'h00000060
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             deq,
  input  logic             flush,
  input  logic [width-1:0] flush_pc,
  input  logic             mem_resp,
  input  logic [width-1:0] mem_rdata,
  output logic             mem_read,
  output logic [width-1:0] mem_address,
  output logic             rdy,
  output logic [width-1:0] out,
  output logic [width-1:0] out_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [width-1:0] PC_INC  = width'(width / 8);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t           state_q, state_d;
  logic [width-1:0] pc_q, pc_d;
  logic [width-1:0] addr_q, addr_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [width-1:0] inst_mem_q [DEPTH];
  logic [width-1:0] pcs_mem_q  [DEPTH];

  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_pop;
  logic [width-1:0] pc_plus;

  assign pc_plus   = pc_q + PC_INC;
  assign pop       = deq && (count_q != '0) && !flush;
  assign count_pop = count_q - CNT_W'(pop);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    push    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Looking at the post-pop count lets a deq on a full FIFO restart
        // fetching in the very next cycle.
        if (!flush && (count_pop < DEPTH_C)) begin
          addr_d  = pc_q;
          state_d = REQ;
        end
      end
      REQ: begin
        if (flush) begin
          state_d = mem_resp ? IDLE : DROP;
        end else if (mem_resp) begin
          push = 1'b1;
          pc_d = pc_plus;
          if ((count_pop + CNT_W'(1)) < DEPTH_C) begin
            addr_d = pc_plus;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (mem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      pc_d = flush_pc;
    end

    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_pop + CNT_W'(push);

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is cleared on reset so out/out_pc read as 0 until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pcs_mem_q[i]  <= '0;
      end
    end else if (push) begin
      inst_mem_q[tail_q] <= mem_rdata;
      pcs_mem_q[tail_q]  <= addr_q;
    end
  end

  assign mem_read    = (state_q != IDLE);
  assign mem_address = addr_q;
  assign rdy         = (count_q != '0);
  assign out         = inst_mem_q[head_q];
  assign out_pc      = pcs_mem_q[head_q];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, streaming, back-pressure, flush,
// squashed responses, underflow and PC wrap, with hand-computed expectations.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        deq = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        mem_resp = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_read;
  logic [31:0] mem_address;
  logic        rdy;
  logic [31:0] out;
  logic [31:0] out_pc;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue dut (
    .clk        (clk),
    .rst        (rst),
    .deq        (deq),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .mem_resp   (mem_resp),
    .mem_rdata  (mem_rdata),
    .mem_read   (mem_read),
    .mem_address(mem_address),
    .rdy        (rdy),
    .out        (out),
    .out_pc     (out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_rdy", {31'b0, rdy}, 32'd0);
    chk("rst_addr", mem_address, 32'h60);
    chk("rst_out", out, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    rst = 1'b0;
    tick();
    chk("first_req", {31'b0, mem_read}, 32'd1);
    chk("first_addr", mem_address, 32'h60);
    chk("first_rdy", {31'b0, rdy}, 32'd0);
    tick();
    chk("wait_req", {31'b0, mem_read}, 32'd1);
    chk("wait_rdy", {31'b0, rdy}, 32'd0);

    // Streaming: response every cycle, dequeue whenever an entry is visible
    for (int i = 0; i < 8; i++) begin
      chk("stream_addr", mem_address, 32'h60 + 32'(4 * i));
      chk("stream_rdy", {31'b0, rdy}, (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) begin
        chk("stream_out_pc", out_pc, 32'h60 + 32'(4 * (i - 1)));
        chk("stream_out", out, instr(32'h60 + 32'(4 * (i - 1))));
      end
      mem_resp  = 1'b1;
      mem_rdata = instr(32'h60 + 32'(4 * i));
      deq       = (i > 0);
      tick();
    end
    mem_resp = 1'b0;
    deq      = 1'b1;
    chk("stream_last_pc", out_pc, 32'h7c);
    tick();
    deq = 1'b0;
    chk("stream_empty", {31'b0, rdy}, 32'd0);
    chk("stream_next_addr", mem_address, 32'h80);

    // Back-pressure: fill all four slots without dequeuing
    for (int i = 0; i < 4; i++) begin
      chk("bp_addr", mem_address, 32'h80 + 32'(4 * i));
      chk("bp_req", {31'b0, mem_read}, 32'd1);
      mem_resp  = 1'b1;
      mem_rdata = instr(32'h80 + 32'(4 * i));
      tick();
    end
    mem_resp = 1'b0;
    chk("full_idle", {31'b0, mem_read}, 32'd0);
    chk("full_rdy", {31'b0, rdy}, 32'd1);
    chk("full_head", out_pc, 32'h80);
    tick();
    chk("full_stays_idle", {31'b0, mem_read}, 32'd0);
    deq = 1'b1;
    tick();
    chk("deq_restart_req", {31'b0, mem_read}, 32'd1);
    chk("deq_restart_addr", mem_address, 32'h90);
    chk("deq_head", out_pc, 32'h84);

    // Push and pop together at count 3, then fill again
    mem_resp  = 1'b1;
    mem_rdata = instr(32'h90);
    deq       = 1'b1;
    tick();
    chk("pushpop_req", {31'b0, mem_read}, 32'd1);
    chk("pushpop_addr", mem_address, 32'h94);
    chk("pushpop_head", out_pc, 32'h88);
    mem_rdata = instr(32'h94);
    deq       = 1'b0;
    tick();
    mem_resp = 1'b0;
    chk("refill_idle", {31'b0, mem_read}, 32'd0);
    chk("refill_head", out_pc, 32'h88);

    // Drain across the wrap point, then dequeue on empty
    deq = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_rdy", {31'b0, rdy}, 32'd1);
      chk("drain_pc", out_pc, 32'h88 + 32'(4 * k));
      chk("drain_out", out, instr(32'h88 + 32'(4 * k)));
      tick();
    end
    chk("drained_rdy", {31'b0, rdy}, 32'd0);
    chk("drained_req", {31'b0, mem_read}, 32'd1);
    chk("drained_addr", mem_address, 32'h98);
    tick();
    chk("underflow_rdy0", {31'b0, rdy}, 32'd0);
    tick();
    chk("underflow_rdy1", {31'b0, rdy}, 32'd0);
    deq       = 1'b0;
    mem_resp  = 1'b1;
    mem_rdata = instr(32'h98);
    tick();
    mem_resp = 1'b0;
    chk("post_uf_rdy", {31'b0, rdy}, 32'd1);
    chk("post_uf_pc", out_pc, 32'h98);
    chk("post_uf_out", out, instr(32'h98));
    chk("post_uf_addr", mem_address, 32'h9c);

    // Flush while a request waits: the stale response is squashed
    flush    = 1'b1;
    flush_pc = 32'h200;
    tick();
    flush = 1'b0;
    chk("drop_req", {31'b0, mem_read}, 32'd1);
    chk("drop_addr", mem_address, 32'h9c);
    chk("drop_rdy", {31'b0, rdy}, 32'd0);
    tick();
    chk("drop_hold_addr", mem_address, 32'h9c);
    chk("drop_hold_rdy", {31'b0, rdy}, 32'd0);
    mem_resp  = 1'b1;
    mem_rdata = 32'hdead_beef;
    tick();
    mem_resp = 1'b0;
    chk("stale_idle", {31'b0, mem_read}, 32'd0);
    chk("stale_rdy", {31'b0, rdy}, 32'd0);
    tick();
    chk("redir_req", {31'b0, mem_read}, 32'd1);
    chk("redir_addr", mem_address, 32'h200);
    chk("redir_rdy", {31'b0, rdy}, 32'd0);

    // Flush coincident with response and deq
    mem_resp  = 1'b1;
    mem_rdata = instr(32'h200);
    tick();
    chk("pre_flush_rdy", {31'b0, rdy}, 32'd1);
    chk("pre_flush_pc", out_pc, 32'h200);
    flush     = 1'b1;
    flush_pc  = 32'h300;
    mem_rdata = 32'h1234_5678;
    deq       = 1'b1;
    tick();
    flush    = 1'b0;
    mem_resp = 1'b0;
    deq      = 1'b0;
    chk("coflush_rdy", {31'b0, rdy}, 32'd0);
    chk("coflush_idle", {31'b0, mem_read}, 32'd0);
    tick();
    chk("coflush_req", {31'b0, mem_read}, 32'd1);
    chk("coflush_addr", mem_address, 32'h300);
    chk("coflush_rdy2", {31'b0, rdy}, 32'd0);

    // PC wraps modulo 2^32
    flush    = 1'b1;
    flush_pc = 32'hffff_fffc;
    tick();
    flush    = 1'b0;
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    tick();
    chk("wrap_addr", mem_address, 32'hffff_fffc);
    mem_resp  = 1'b1;
    mem_rdata = instr(32'hffff_fffc);
    tick();
    mem_resp = 1'b0;
    chk("wrap_next_addr", mem_address, 32'h0);
    chk("wrap_out_pc", out_pc, 32'hffff_fffc);

    // Reset in the middle of a request
    rst = 1'b1;
    tick();
    chk("midrst_read", {31'b0, mem_read}, 32'd0);
    chk("midrst_addr", mem_address, 32'h60);
    chk("midrst_rdy", {31'b0, rdy}, 32'd0);
    chk("midrst_out_pc", out_pc, 32'h0);
    rst = 1'b0;
    tick();
    chk("midrst_req", {31'b0, mem_read}, 32'd1);
    chk("midrst_req_addr", mem_address, 32'h60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Next-generation instruction fetcher. It owns the PC, issues blocking single-outstanding reads to the I-side memory/cache, and buffers returned instructions with their PCs in a DEPTH-entry FIFO for decode.
- Adds PC sequencing, request/response decoupling, back-pressure and branch-redirect flush with stale-response squashing.
- Sits between the instruction cache port and the decode/issue stage.

Parameters:
- width, 32, data/address width in bits; PC increment is width/8.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- RESET_PC, 32'h00000060, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- deq  in  1  consumer pops head entry this cycle; ignored when rdy=0.
- flush  in  1  redirect request; discards FIFO contents and any in-flight request.
- flush_pc  in  width  new fetch PC, valid when flush=1.
- mem_resp  in  1  memory completes the current read; mem_rdata is valid this cycle.
- mem_rdata  in  width  instruction returned by memory.
- mem_read  out  1  read request; held high until mem_resp.
- mem_address  out  width  request address; registered and stable while mem_read=1.
- rdy  out  1  FIFO non-empty.
- out  out  width  head instruction.
- out_pc  out  width  PC of head instruction.

Behaviour:
- Reset (rst=1 at edge):
  - pc←RESET_PC; FIFO empty (head=tail=count=0); state←IDLE; mem_address←RESET_PC.
  - Outputs after reset: mem_read=0, rdy=0, out/out_pc undefined-but-stable (0).
  - Reset mid-request abandons the request with no drop state. Memory must tolerate mem_read falling before mem_resp.
- States: IDLE, REQ, DROP. mem_read=1 in REQ and DROP, otherwise 0.
- IDLE:
  - If !flush and count<DEPTH: mem_address←pc, go to REQ.
  - First mem_read is asserted the cycle after rst deasserts.
- REQ:
  - mem_resp && !flush: push {mem_address, mem_rdata}; pc←pc+width/8.
    - If count_next<DEPTH: mem_address←pc+width/8 and stay in REQ, giving back-to-back fetch with mem_read held high.
    - Otherwise go to IDLE.
  - flush && !mem_resp: go to DROP; mem_address held.
  - flush && mem_resp: data discarded; go to IDLE.
- DROP:
  - Waits for the stale response. mem_resp → discard, go to IDLE.
  - flush while in DROP only updates pc.
- Flush, any state:
  - pc←flush_pc; FIFO cleared (count=0, rdy=0 next cycle); deq in the same cycle is ignored.
  - A flush from IDLE goes to IDLE; the new request issues the following cycle.
- FIFO:
  - Circular; head/tail wrap modulo DEPTH.
  - Push and pop in the same cycle leaves count unchanged and is legal when full or when count=1.
  - A push into an empty FIFO makes the entry visible (rdy=1) the next cycle. There is no bypass.
  - A request is issued only when a slot is free, so a push can never overflow.
  - count is width $clog2(DEPTH)+1.
- Arithmetic: PC addition wraps modulo 2^width.
- Precedence: rst > flush > mem_resp/deq.

Test Plan:
- Reset then idle memory: after rst, mem_read=1 with mem_address=0x60 on cycle 1. rdy stays 0 until the first mem_resp.
- Streaming: mem_resp every cycle, deq whenever rdy. Addresses are 0x60, 0x64, 0x68… and out_pc/out match in order with no gaps or duplicates.
- Back-pressure, DEPTH=4, deq=0:
  - After 4 responses, mem_read=0 and state is IDLE.
  - One deq brings mem_read=1 the next cycle with address 0x70.
  - Wraparound of head/tail is checked over 10 entries.
- Flush mid-request: flush=1, flush_pc=0x200 while waiting.
  - mem_address stays at the old value until mem_resp; that data is not pushed.
  - The next request goes to 0x200 and rdy=0 throughout.
- Flush coincident with mem_resp and deq: nothing pushed or popped; FIFO empty; the next request goes to flush_pc.
- Full FIFO with simultaneous deq+push and deq on empty: count stays at DEPTH; deq with rdy=0 causes no underflow and count stays 0.
